// File: rtl/pc_gen.sv
// Fetch-address generator: fetch/decide FSM, in-flight branch prediction FIFO, mispredict recovery
// and predictor training strobe. Define PC_GEN_PREDICT_EN to let the predictor steer the next pc.
module pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        if_ack_i,
  input  logic [31:0] if_inst_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        hold_i,
  input  logic        bp_result_i,
  input  logic [31:0] bp_jump_addr_i,
  input  logic        ex_resolve_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  output logic        flush_o,
  output logic        last_need_predict_o,
  output logic        last_jump_o,
  output logic [31:0] last_addr_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic {S_FETCH, S_DECIDE} state_t;

  state_t             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        inst_q;
  logic [31:0]        inst_addr_q;

  logic [31:0]        fifo_addr_q [FIFO_DEPTH];
  logic [31:0]        fifo_tgt_q  [FIFO_DEPTH];
  logic               fifo_tkn_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic               last_need_q;
  logic               last_jump_q;
  logic [31:0]        last_addr_q;

  logic               is_branch;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               mispredict;
  logic               valid;
  logic               transfer;
  logic               pred_taken;
  logic [31:0]        seq_addr;
  logic [31:0]        pc_pred_d;
  logic [31:0]        pc_fix_d;

  assign seq_addr   = inst_addr_q + 32'd4;
  assign is_branch  = (inst_q[6:0] == OP_JAL) || (inst_q[6:0] == OP_BR);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign pop        = ex_resolve_i && !fifo_empty;
  assign mispredict = pop && ((ex_taken_i != fifo_tkn_q[rd_ptr_q]) ||
                              (ex_taken_i && (ex_target_i != fifo_tgt_q[rd_ptr_q])));
  assign pc_fix_d   = ex_taken_i ? ex_target_i : (fifo_addr_q[rd_ptr_q] + 32'd4);

  // A full FIFO blocks a branch unless the head leaves this same cycle.
  assign valid      = (state_q == S_DECIDE) && !mispredict &&
                      !(is_branch && fifo_full && !pop);
  assign transfer   = valid && !hold_i;
  assign push       = transfer && is_branch;

`ifdef PC_GEN_PREDICT_EN
  assign pred_taken = is_branch && bp_result_i;
  assign pc_pred_d  = pred_taken ? bp_jump_addr_i : seq_addr;
`else
  logic unused_bp;
  assign unused_bp  = ^{bp_result_i, bp_jump_addr_i};
  assign pred_taken = 1'b0;
  assign pc_pred_d  = seq_addr;
`endif

  assign count_d = mispredict ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));

  // Fetch/decide FSM; a mispredict overrides both states, dropping any same-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_addr_q <= '0;
    end else if (mispredict) begin
      state_q <= S_FETCH;
      pc_q    <= pc_fix_d;
    end else if (state_q == S_FETCH) begin
      if (if_ack_i) begin
        inst_q      <= if_inst_i;
        inst_addr_q <= pc_q;
        state_q     <= S_DECIDE;
      end
    end else begin
      if (transfer) begin
        pc_q    <= pc_pred_d;
        state_q <= S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= inst_addr_q;
      fifo_tkn_q[wr_ptr_q]  <= pred_taken;
      fifo_tgt_q[wr_ptr_q]  <= pc_pred_d;
    end
  end

  // Training strobe follows every pop by one cycle, mispredicted or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_need_q <= 1'b0;
      last_jump_q <= 1'b0;
      last_addr_q <= '0;
    end else begin
      last_need_q <= pop;
      if (pop) begin
        last_jump_q <= ex_taken_i;
        last_addr_q <= fifo_addr_q[rd_ptr_q];
      end
    end
  end

  assign if_req_o            = !rst && (state_q == S_FETCH);
  assign if_addr_o           = rst ? RESET_PC : pc_q;
  assign inst_o              = rst ? '0 : inst_q;
  assign inst_addr_o         = rst ? '0 : inst_addr_q;
  assign inst_valid_o        = !rst && valid;
  assign flush_o             = !rst && mispredict;
  assign last_need_predict_o = !rst && last_need_q;
  assign last_jump_o         = !rst && last_jump_q;
  assign last_addr_o         = rst ? '0 : last_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a transaction-level reference model checked every cycle.
module tb_pc_gen;

`ifdef PC_GEN_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BR    = 32'h0000_0063;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        if_ack_i = 1'b0;
  logic [31:0] if_inst_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        hold_i = 1'b0;
  logic        bp_result_i = 1'b0;
  logic [31:0] bp_jump_addr_i = '0;
  logic        ex_resolve_i = 1'b0;
  logic        ex_taken_i = 1'b0;
  logic [31:0] ex_target_i = '0;
  logic        flush_o;
  logic        last_need_predict_o;
  logic        last_jump_o;
  logic [31:0] last_addr_o;

  pc_gen dut (
    .clk(clk), .rst(rst),
    .if_req_o(if_req_o), .if_addr_o(if_addr_o), .if_ack_i(if_ack_i), .if_inst_i(if_inst_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o), .hold_i(hold_i),
    .bp_result_i(bp_result_i), .bp_jump_addr_i(bp_jump_addr_i),
    .ex_resolve_i(ex_resolve_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .flush_o(flush_o), .last_need_predict_o(last_need_predict_o),
    .last_jump_o(last_jump_o), .last_addr_o(last_addr_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // Instruction memory answering whatever address is being fetched.
  logic [31:0] imem [64];
  always @(posedge clk) begin
    #1;
    if_inst_i = imem[if_addr_o[7:2]];
  end

  // Reference model: fetch/decide as a transaction, predictions as a queue.
  typedef struct packed {
    logic [31:0] addr;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  pred_t       predq[$];
  logic        m_fetch = 1'b1;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_iaddr = '0;
  logic        m_tv = 1'b0;
  logic        m_tj = 1'b0;
  logic [31:0] m_ta = '0;

  function automatic logic is_br(input logic [31:0] w);
    return (w[6:0] == 7'h6F) || (w[6:0] == 7'h63);
  endfunction

  always @(negedge clk) begin : model
    logic        br, pop, mis, valid, ptk;
    logic [31:0] nxt;
    pred_t       h, e;
    if (rst) begin
      chk("mdl_rst_if_req", if_req_o, 0);
      chk("mdl_rst_if_addr", if_addr_o, 0);
      chk("mdl_rst_inst", inst_o, 0);
      chk("mdl_rst_inst_addr", inst_addr_o, 0);
      chk("mdl_rst_valid", inst_valid_o, 0);
      chk("mdl_rst_flush", flush_o, 0);
      chk("mdl_rst_need", last_need_predict_o, 0);
      chk("mdl_rst_jump", last_jump_o, 0);
      chk("mdl_rst_laddr", last_addr_o, 0);
      predq.delete();
      m_fetch = 1'b1; m_pc = '0; m_tv = 1'b0; m_tj = 1'b0; m_ta = '0;
    end else begin
      br  = is_br(m_inst);
      pop = ex_resolve_i && (predq.size() > 0);
      mis = 1'b0;
      h   = '0;
      if (pop) begin
        h   = predq[0];
        mis = (ex_taken_i != h.taken) || (ex_taken_i && (ex_target_i != h.target));
      end
      valid = !m_fetch && !mis && !(br && (predq.size() == DEPTH) && !pop);
      chk("mdl_if_req", if_req_o, m_fetch);
      if (m_fetch) chk("mdl_if_addr", if_addr_o, m_pc);
      else begin
        chk("mdl_inst", inst_o, m_inst);
        chk("mdl_inst_addr", inst_addr_o, m_iaddr);
      end
      chk("mdl_valid", inst_valid_o, valid);
      chk("mdl_flush", flush_o, mis);
      chk("mdl_need", last_need_predict_o, m_tv);
      if (m_tv) begin
        chk("mdl_jump", last_jump_o, m_tj);
        chk("mdl_laddr", last_addr_o, m_ta);
      end
      m_tv = pop;
      if (pop) begin m_tj = ex_taken_i; m_ta = h.addr; end
      if (mis) begin
        predq.delete();
        m_fetch = 1'b1;
        m_pc    = ex_taken_i ? ex_target_i : h.addr + 32'd4;
      end else begin
        if (pop) void'(predq.pop_front());
        if (m_fetch) begin
          if (if_ack_i) begin m_inst = if_inst_i; m_iaddr = m_pc; m_fetch = 1'b0; end
        end else if (valid && !hold_i) begin
          ptk = PRED && br && bp_result_i;
          nxt = ptk ? bp_jump_addr_i : m_iaddr + 32'd4;
          if (br) begin e.addr = m_iaddr; e.taken = ptk; e.target = nxt; predq.push_back(e); end
          m_fetch = 1'b1;
          m_pc    = nxt;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    hold_i = 0; bp_result_i = 0; bp_jump_addr_i = '0;
    ex_resolve_i = 0; ex_taken_i = 0; ex_target_i = '0; if_ack_i = 1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) imem[i] = NOP;
  endtask

  // Reset, then release: returns in the first cycle after rst falls.
  task automatic start();
    tick(); rst = 1; quiet();
    tick(); tick(); tick();
    rst = 0;
  endtask

  initial begin
    fill_nop();
    quiet();
    tick(); tick(); #1;
    chk("reset_if_req", if_req_o, 0);
    chk("reset_if_addr", if_addr_o, 0);
    chk("reset_valid", inst_valid_o, 0);
    chk("reset_need", last_need_predict_o, 0);

    // Sequential fetch of plain words
    start(); #1;
    chk("seq_c1_req", if_req_o, 1);
    chk("seq_c1_addr", if_addr_o, 32'h0);
    tick(); #1;
    chk("seq_c2_valid", inst_valid_o, 1);
    chk("seq_c2_inst", inst_o, NOP);
    tick(); #1;
    chk("seq_c3_addr", if_addr_o, 32'h4);
    tick(); tick(); #1;
    chk("seq_c5_addr", if_addr_o, 32'h8);

    // Predicted-taken branch at 0x10, resolved taken to 0x40
    imem[4] = BR;
    start();
    repeat (9) tick();
    bp_result_i = 1; bp_jump_addr_i = 32'h40; #1;
    chk("bt_inst", inst_o, BR);
    chk("bt_inst_addr", inst_addr_o, 32'h10);
    tick();
    bp_result_i = 0; ex_resolve_i = 1; ex_taken_i = 1; ex_target_i = 32'h40; #1;
    chk("bt_next_addr", if_addr_o, PRED ? 32'h40 : 32'h14);
    chk("bt_flush", flush_o, !PRED);
    tick();
    ex_resolve_i = 0; #1;
    chk("bt_need", last_need_predict_o, 1);
    chk("bt_laddr", last_addr_o, 32'h10);
    chk("bt_ljump", last_jump_o, 1);
    chk("bt_if_req", if_req_o, !PRED);
    tick(); #1;
    chk("bt_need_drop", last_need_predict_o, 0);

    // Same branch resolved not-taken
    start();
    repeat (9) tick();
    bp_result_i = 1; bp_jump_addr_i = 32'h40;
    tick();
    bp_result_i = 0; if_ack_i = 0; ex_resolve_i = 1; ex_taken_i = 0; ex_target_i = 32'h0; #1;
    chk("bn_flush", flush_o, PRED);
    tick();
    ex_resolve_i = 1; #1;
    chk("bn_if_req", if_req_o, 1);
    chk("bn_if_addr", if_addr_o, 32'h14);
    chk("bn_need", last_need_predict_o, 1);
    chk("bn_ljump", last_jump_o, 0);
    chk("bn_empty_flush", flush_o, 0);
    tick();
    ex_resolve_i = 0; if_ack_i = 1; #1;
    chk("bn_empty_need", last_need_predict_o, 0);
    chk("bn_if_addr2", if_addr_o, 32'h14);

    // FIFO full: fifth branch waits for a pop
    fill_nop();
    for (int i = 0; i < 5; i++) imem[i] = BR;
    start();
    repeat (9) tick(); #1;
    chk("full_valid_c10", inst_valid_o, 0);
    chk("full_req_c10", if_req_o, 0);
    tick(); #1;
    chk("full_valid_c11", inst_valid_o, 0);
    tick();
    ex_resolve_i = 1; ex_taken_i = 0; #1;
    chk("full_valid_pop", inst_valid_o, 1);
    chk("full_flush", flush_o, 0);
    tick();
    ex_resolve_i = 0; #1;
    chk("full_next_addr", if_addr_o, 32'h14);
    chk("full_need", last_need_predict_o, 1);
    chk("full_laddr", last_addr_o, 32'h0);

    // Decode stall
    fill_nop();
    start();
    tick(); hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_inst_addr", inst_addr_o, 32'h0);
      chk("hold_inst", inst_o, NOP);
      chk("hold_req", if_req_o, 0);
      tick();
    end
    hold_i = 0; #1;
    chk("hold_release_valid", inst_valid_o, 1);
    tick(); if_ack_i = 0; #1;
    chk("hold_next_addr", if_addr_o, 32'h4);
    tick(); #1;
    chk("noack_req", if_req_o, 1);
    chk("noack_addr", if_addr_o, 32'h4);
    tick(); if_ack_i = 1;
    tick(); #1;
    chk("ack_decide_addr", inst_addr_o, 32'h4);

    // Mispredicts against a pending push and against a fetch ack
    imem[0] = BR; imem[1] = BR; imem[9] = BR;
    start();
    tick(); tick(); tick();
    ex_resolve_i = 1; ex_taken_i = 1; ex_target_i = 32'h20; #1;
    chk("mp_push_flush", flush_o, 1);
    chk("mp_push_valid", inst_valid_o, 0);
    tick();
    ex_resolve_i = 1; ex_taken_i = 0; #1;
    chk("mp_push_addr", if_addr_o, 32'h20);
    chk("mp_push_need", last_need_predict_o, 1);
    chk("mp_push_ljump", last_jump_o, 1);
    chk("mp_push_empty", flush_o, 0);
    tick();
    ex_resolve_i = 0; #1;
    chk("mp_push_need2", last_need_predict_o, 0);
    tick(); tick(); tick();
    ex_resolve_i = 1; ex_taken_i = 1; ex_target_i = 32'h60; #1;
    chk("mp_ack_flush", flush_o, 1);
    tick();
    ex_resolve_i = 0; #1;
    chk("mp_ack_req", if_req_o, 1);
    chk("mp_ack_addr", if_addr_o, 32'h60);
    chk("mp_ack_laddr", last_addr_o, 32'h24);
    tick();
    ex_resolve_i = 1; ex_taken_i = 0; #1;
    chk("mp_ack_empty", flush_o, 0);
    tick();
    ex_resolve_i = 0; #1;
    chk("mp_ack_need2", last_need_predict_o, 0);

    // Reset in mid-flight discards the queued prediction
    fill_nop();
    imem[0] = BR;
    start();
    tick(); tick();
    if_ack_i = 0; rst = 1; #1;
    chk("midrst_req", if_req_o, 0);
    chk("midrst_inst", inst_o, 0);
    chk("midrst_valid", inst_valid_o, 0);
    tick(); tick();
    rst = 0; if_ack_i = 1; ex_resolve_i = 1; ex_taken_i = 1; ex_target_i = 32'h88; #1;
    chk("midrst_c1_addr", if_addr_o, 32'h0);
    chk("midrst_flush", flush_o, 0);
    tick();
    ex_resolve_i = 0; #1;
    chk("midrst_need", last_need_predict_o, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..8), giving the number of in-flight prediction entries.
REQ-003 The module SHALL have the following ports; reset is rst, synchronous, active-high, and the clock is clk.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req_o  out  1  fetch request to instruction memory
- if_addr_o  out  32  fetch address
- if_ack_i  in  1  fetch acknowledge; if_inst_i valid this cycle
- if_inst_i  in  32  fetched instruction
- inst_o  out  32  held instruction, fed to the predictor and to decode
- inst_addr_o  out  32  address of inst_o
- inst_valid_o  out  1  inst_o offered to decode
- hold_i  in  1  decode stall
- bp_result_i  in  1  predictor taken decision for inst_o
- bp_jump_addr_i  in  32  predictor target for inst_o
- ex_resolve_i  in  1  execute resolved the oldest JAL/B-type instruction
- ex_taken_i  in  1  actual outcome of the resolved instruction
- ex_target_i  in  32  actual target of the resolved instruction
- flush_o  out  1  mispredict flush pulse
- last_need_predict_o  out  1  predictor training strobe
- last_jump_o  out  1  training outcome
- last_addr_o  out  32  training address

Function
REQ-004 The module SHALL implement a two-state FSM: FETCH (if_req_o=1, if_addr_o=pc) and DECIDE (instruction held, if_req_o=0).
REQ-005 In FETCH, if_ack_i=1 SHALL capture if_inst_i into inst_o and pc into inst_addr_o, and move to DECIDE on the next cycle; if_ack_i=0 SHALL remain in FETCH with if_addr_o unchanged.
REQ-006 An instruction is a branch when opcode inst_o[6:0] is 7'b1101111 (JAL) or 7'b1100011 (B-type).
REQ-007 In DECIDE, inst_valid_o SHALL be 1 unless the instruction is a branch and the FIFO is full with no pop this cycle.
REQ-008 A transfer SHALL occur when inst_valid_o=1 and hold_i=0.
REQ-009 On transfer, the FSM SHALL move to FETCH with pc = bp_jump_addr_i if the instruction is a branch and bp_result_i=1, else pc = inst_addr_o+4 (modulo 2^32).
REQ-010 On transfer of a branch, {inst_addr_o, predicted_taken, predicted_target} SHALL be pushed into the FIFO; the predicted_target of a not-taken prediction is inst_addr_o+4.
REQ-011 When ex_resolve_i=1 and the FIFO is non-empty, the head SHALL be popped.
REQ-012 A popped entry is a mispredict when ex_taken_i != predicted_taken, or when ex_taken_i=1 and ex_target_i != predicted_target.
REQ-013 On mispredict, flush_o SHALL be 1 for exactly that cycle (combinational).
REQ-014 On mispredict, the following SHALL take effect in the same cycle:
- the FIFO is emptied, including any same-cycle push;
- inst_valid_o and the DECIDE hold are cancelled;
- the FSM moves to FETCH next cycle with pc = ex_target_i if taken, else head address+4.
REQ-015 If a mispredict coincides with an if_ack_i, the fetched data SHALL be discarded.
REQ-016 A push and a non-mispredict pop in the same cycle SHALL both be honoured, including when the FIFO is full (count unchanged).
REQ-017 ex_resolve_i with an empty FIFO SHALL be ignored: no flush and no training strobe.
REQ-018 Every pop SHALL produce last_need_predict_o=1 on the next cycle, with last_jump_o=ex_taken_i and last_addr_o=head address, registered.
REQ-019 last_need_predict_o SHALL be 0 in all other cycles.
REQ-020 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 While rst=1, the outputs SHALL be held at the following values:
- if_req_o=0, if_addr_o=RESET_PC, inst_o=0, inst_addr_o=0, inst_valid_o=0;
- flush_o=0, last_need_predict_o=0, last_jump_o=0, last_addr_o=0.
REQ-022 While rst=1, the FIFO SHALL be emptied and the FSM forced to FETCH with pc=RESET_PC.
REQ-023 Reset asserted mid-fetch or mid-hold SHALL abandon all in-flight state.
REQ-024 In the first cycle after rst falls, if_req_o SHALL be 1 with if_addr_o=RESET_PC.

Configuration
REQ-025 When macro PC_GEN_PREDICT_EN is defined, bp_result_i and bp_jump_addr_i SHALL steer the next pc per REQ-009.
REQ-026 When PC_GEN_PREDICT_EN is undefined, bp_result_i and bp_jump_addr_i SHALL be ignored: every branch is predicted not-taken, the next pc is inst_addr_o+4, and the FIFO records predicted_taken=0; all other behaviour is unchanged.

Verification
REQ-027 The bench SHALL cover: reset release with ack each FETCH and non-branch words -> if_addr_o sequence 0x0, 0x4, 0x8 in cycles 1, 3, 5.
REQ-028 The bench SHALL cover: B-type at 0x10, bp_result_i=1, bp_jump_addr_i=0x40 -> next if_addr_o=0x40; ex_resolve_i with ex_taken_i=1, ex_target_i=0x40 -> no flush, then last_need_predict_o=1, last_addr_o=0x10, last_jump_o=1.
REQ-029 The bench SHALL cover: the same branch resolved ex_taken_i=0 -> flush_o pulses 1 cycle, FIFO empty, next if_addr_o=0x14.
REQ-030 The bench SHALL cover: four unresolved branches with hold_i=0 -> a fifth branch gives inst_valid_o=0 until ex_resolve_i (no mispredict), then it transfers in that cycle.
REQ-031 The bench SHALL cover: hold_i=1 for 3 cycles in DECIDE -> inst_o/inst_addr_o stable and if_req_o=0; then one transfer.
REQ-032 The bench SHALL cover: mispredict coincident with if_ack_i and a pending push -> fetched word dropped, FIFO count 0, fetch restarts at the corrected pc.
